// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the kernel block dispatcher.
package dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sched_state_t;

   typedef enum logic [1:0] {
      FREE      = 2'd0,
      RUNNING   = 2'd1,
      RESETTING = 2'd2
   } slot_state_t;

   // A block size of zero, or one larger than the hardware supports,
   // falls back to the largest supported size.
   function automatic int unsigned clamp_block_size(input int unsigned bs,
                                                    input int unsigned max_bs);
      if (bs == 0 || bs > max_bs) begin
         return max_bs;
      end
      return bs;
   endfunction

endpackage

// File: rtl/core_slot.sv
// One dispatch slot: tracks a single core through FREE -> RUNNING -> RESETTING.
// abort_i parks the slot in reset (kernel not running, or core disabled).
module core_slot
   import dispatch_pkg::*;
#(
   parameter int ID_W = 16,
   parameter int TC_W = 4
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            abort_i,
   input  logic            grant_i,
   input  logic            done_i,
   input  logic [ID_W-1:0] block_id_i,
   input  logic [TC_W-1:0] count_i,
   output logic            core_start_o,
   output logic            core_reset_o,
   output logic [ID_W-1:0] core_block_id_o,
   output logic [TC_W-1:0] core_thread_count_o,
   output logic            free_o,
   output logic            active_o
);

   slot_state_t     state_q, state_d;
   logic            start_q, start_d;
   logic            rst_q, rst_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [TC_W-1:0] cnt_q, cnt_d;

   // Slot register; a fresh slot sits in reset until the kernel arms it.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= RESETTING;
         start_q <= 1'b0;
         rst_q   <= 1'b1;
         id_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         rst_q   <= rst_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: abort wins, done is only honoured while the block is running.
   always_comb begin
      state_d = state_q;
      start_d = start_q;
      rst_d   = rst_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      if (abort_i) begin
         state_d = RESETTING;
         start_d = 1'b0;
         rst_d   = 1'b1;
         id_d    = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            FREE: begin
               if (grant_i) begin
                  state_d = RUNNING;
                  start_d = 1'b1;
                  id_d    = block_id_i;
                  cnt_d   = count_i;
               end
            end
            RUNNING: begin
               if (done_i && start_q) begin
                  state_d = RESETTING;
                  start_d = 1'b0;
                  rst_d   = 1'b1;
               end
            end
            RESETTING: begin
               state_d = FREE;
               rst_d   = 1'b0;
            end
            default: begin
               state_d = RESETTING;
               rst_d   = 1'b1;
            end
         endcase
      end
   end

   assign core_start_o        = start_q;
   assign core_reset_o        = rst_q;
   assign core_block_id_o     = id_q;
   assign core_thread_count_o = cnt_q;
   assign free_o              = (state_q == FREE);
   assign active_o            = (state_q != FREE);

endmodule

// File: rtl/block_scheduler.sv
// Kernel dispatcher: splits a thread count into blocks of a runtime size and
// hands them one per cycle to the lowest-index free, enabled core.
module block_scheduler
   import dispatch_pkg::*;
#(
   parameter int NUM_CORES             = 4,
   parameter int MAX_THREADS_PER_BLOCK = 8,
   parameter int THREAD_COUNT_WIDTH    = 16,
   parameter int TC_W                  = $clog2(MAX_THREADS_PER_BLOCK) + 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [THREAD_COUNT_WIDTH-1:0]        thread_count,
   input  logic [TC_W-1:0]                      threads_per_block,
   input  logic [NUM_CORES-1:0]                 core_enable,
   input  logic [NUM_CORES-1:0]                 core_done,
   output logic [NUM_CORES-1:0]                 core_start,
   output logic [NUM_CORES-1:0]                 core_reset,
   output logic [NUM_CORES*THREAD_COUNT_WIDTH-1:0] core_block_id,
   output logic [NUM_CORES*TC_W-1:0]            core_thread_count,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 error
);

   sched_state_t                  state_q, state_d;
   logic [THREAD_COUNT_WIDTH-1:0] remaining_q, remaining_d;
   logic [THREAD_COUNT_WIDTH-1:0] next_id_q, next_id_d;
   logic [TC_W-1:0]               bs_q, bs_d;
   logic [NUM_CORES-1:0]          en_q, en_d;
   logic                          error_q, error_d;

   logic [NUM_CORES-1:0] slot_free;
   logic [NUM_CORES-1:0] slot_active;
   logic [NUM_CORES-1:0] slot_abort;
   logic [NUM_CORES-1:0] grant;
   logic                 dispatch;
   logic [TC_W-1:0]      disp_count;
   logic                 slots_busy;

   // Only enabled slots count as work in flight; disabled ones are parked.
   assign slots_busy = |(slot_active & en_q);

   // Last block may be short: take whatever is left when below the block size.
   assign disp_count = (remaining_q < THREAD_COUNT_WIDTH'(bs_q)) ?
                       remaining_q[TC_W-1:0] : bs_q;

   // Lowest-index free enabled slot wins; at most one grant per cycle.
   always_comb begin
      grant    = '0;
      dispatch = 1'b0;
      if (state_q == RUN && start && remaining_q != '0) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (!dispatch && slot_free[i] && en_q[i]) begin
               grant[i] = 1'b1;
               dispatch = 1'b1;
            end
         end
      end
   end

   // Top state and launch-time latches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         next_id_q   <= '0;
         bs_q        <= '0;
         en_q        <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         next_id_q   <= next_id_d;
         bs_q        <= bs_d;
         en_q        <= en_d;
         error_q     <= error_d;
      end
   end

   // Launch/abort/complete decisions and counter updates; slots are parked
   // unless the kernel will be running next cycle with that core enabled.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      next_id_d   = next_id_q;
      bs_d        = bs_q;
      en_d        = en_q;
      error_d     = error_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (thread_count != '0 && core_enable == '0) begin
                  state_d = DONE;
                  error_d = 1'b1;
               end else begin
                  state_d     = RUN;
                  error_d     = 1'b0;
                  remaining_d = thread_count;
                  next_id_d   = '0;
                  bs_d        = TC_W'(clamp_block_size(32'(threads_per_block),
                                                       32'(MAX_THREADS_PER_BLOCK)));
                  en_d        = core_enable;
               end
            end
         end
         RUN: begin
            if (!start) begin
               state_d = IDLE;
            end else if (remaining_q == '0 && !slots_busy) begin
               state_d = DONE;
            end else if (dispatch) begin
               remaining_d = remaining_q - THREAD_COUNT_WIDTH'(disp_count);
               next_id_d   = next_id_q + 1'b1;
            end
         end
         DONE: begin
            if (!start) begin
               state_d = IDLE;
               error_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      slot_abort = (state_d == RUN) ? ~en_d : '1;
   end

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
      core_slot #(
         .ID_W (THREAD_COUNT_WIDTH),
         .TC_W (TC_W)
      ) u_slot (
         .clk_i               (clk),
         .reset_i             (reset),
         .abort_i             (slot_abort[i]),
         .grant_i             (grant[i]),
         .done_i              (core_done[i]),
         .block_id_i          (next_id_q),
         .count_i             (disp_count),
         .core_start_o        (core_start[i]),
         .core_reset_o        (core_reset[i]),
         .core_block_id_o     (core_block_id[i*THREAD_COUNT_WIDTH +: THREAD_COUNT_WIDTH]),
         .core_thread_count_o (core_thread_count[i*TC_W +: TC_W]),
         .free_o              (slot_free[i]),
         .active_o            (slot_active[i])
      );
   end

   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign error = (state_q == DONE) && error_q;

endmodule

// File: tb/tb_block_scheduler.sv
// Bench for block_scheduler: core responder, dispatch scoreboard, directed kernels.
module tb_block_scheduler;

   localparam int NC   = 4;
   localparam int MAXT = 8;
   localparam int W    = 16;
   localparam int TCW  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [W-1:0]      thread_count;
   logic [TCW-1:0]    threads_per_block;
   logic [NC-1:0]     core_enable;
   logic [NC-1:0]     core_done;
   logic [NC-1:0]     core_start;
   logic [NC-1:0]     core_reset;
   logic [NC*W-1:0]   core_block_id;
   logic [NC*TCW-1:0] core_thread_count;
   logic              busy;
   logic              done;
   logic              error;

   block_scheduler #(
      .NUM_CORES             (NC),
      .MAX_THREADS_PER_BLOCK (MAXT),
      .THREAD_COUNT_WIDTH    (W)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .thread_count      (thread_count),
      .threads_per_block (threads_per_block),
      .core_enable       (core_enable),
      .core_done         (core_done),
      .core_start        (core_start),
      .core_reset        (core_reset),
      .core_block_id     (core_block_id),
      .core_thread_count (core_thread_count),
      .busy              (busy),
      .done              (done),
      .error             (error)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W+TCW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_disp   = 0;
   int disp_core[$];
   int last_done_cyc[NC];
   int last_any_done = -1;

   bit            resp_auto  = 1'b1;
   int            resp_delay = 5;
   logic [NC-1:0] extra_done = '0;
   bit            gap_chk    = 1'b0;
   bit            watch0     = 1'b0;
   int            bad0       = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- core responder ----------------
   initial begin
      int            age[NC];
      logic [NC-1:0] auto_d;
      core_done = '0;
      for (int i = 0; i < NC; i++) begin
         age[i] = 0;
         last_done_cyc[i] = -1;
      end
      forever begin
         @(negedge clk);
         auto_d = '0;
         for (int i = 0; i < NC; i++) begin
            if (core_start[i]) age[i]++;
            else age[i] = 0;
            if (resp_auto && core_start[i] && age[i] == resp_delay) auto_d[i] = 1'b1;
         end
         #1;
         core_done = auto_d | extra_done;
         for (int i = 0; i < NC; i++) begin
            if (core_done[i] && core_start[i]) begin
               last_done_cyc[i] = cyc;
               last_any_done    = cyc;
            end
         end
      end
   end

   // ---------------- dispatch monitor ----------------
   initial begin
      logic [NC-1:0]    prev;
      logic [NC-1:0]    rise;
      logic [W+TCW-1:0] e;
      prev = '0;
      forever begin
         @(negedge clk);
         rise = core_start & ~prev;
         prev = core_start;
         if (watch0 && core_reset[0] !== 1'b1) bad0++;
         if (rise != '0) begin
            check("one_dispatch_per_cycle", $countones(rise), 1);
            for (int i = 0; i < NC; i++) begin
               if (rise[i]) begin
                  check("sb_nonempty", exp_q.size() != 0, 1);
                  if (exp_q.size() != 0) begin
                     e = exp_q.pop_front();
                     check("blk_id", core_block_id[i*W +: W], e[W+TCW-1:TCW]);
                     check("blk_cnt", core_thread_count[i*TCW +: TCW], e[TCW-1:0]);
                  end
                  disp_core.push_back(i);
                  n_disp++;
                  if (gap_chk && last_done_cyc[i] >= 0)
                     check("restart_gap", cyc - last_done_cyc[i], 3);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Builds the expected block list, drives the launch, and returns at the
   // sample point just after the launch edge. Inputs are then scrambled.
   task automatic launch(input int tc, input int bs, input logic [NC-1:0] en);
      int rem, bsc, id, c;
      bsc = (bs == 0 || bs > MAXT) ? MAXT : bs;
      rem = tc;
      id  = 0;
      if (en != '0) begin
         while (rem > 0) begin
            c = (rem < bsc) ? rem : bsc;
            exp_q.push_back({W'(id), TCW'(c)});
            rem -= c;
            id++;
         end
      end
      for (int i = 0; i < NC; i++) last_done_cyc[i] = -1;
      last_any_done = -1;
      @(negedge clk);
      thread_count      = W'(tc);
      threads_per_block = TCW'(bs);
      core_enable       = en;
      start             = 1'b1;
      @(negedge clk);
      thread_count      = W'($urandom_range(0, 65535));
      threads_per_block = TCW'($urandom_range(0, 15));
      core_enable       = NC'($urandom_range(0, 15));
   endtask

   task automatic wait_done(input int max_cycles, output int at_cyc);
      int n;
      n = 0;
      while (done !== 1'b1 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check("done_reached", done, 1);
      at_cyc = cyc;
   endtask

   task automatic wait_disp(input int base, input int target, input int max_cycles);
      int n;
      n = 0;
      while ((n_disp - base) < target && n < max_cycles) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("disp_reached", n_disp - base, target);
   endtask

   task automatic end_kernel();
      check("sb_drained", exp_q.size(), 0);
      exp_q.delete();
      start = 1'b0;
      @(negedge clk);
      check("idle_start", core_start, 0);
      check("idle_reset", core_reset, 4'hF);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_error", error, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t, base;
      int bs_list[2];
      reset = 1'b1;
      start = 1'b0;
      thread_count = '0;
      threads_per_block = '0;
      core_enable = '0;
      repeat (3) @(negedge clk);
      check("rst_core_reset", core_reset, 4'hF);
      check("rst_core_start", core_start, 0);
      for (int i = 0; i < NC; i++) begin
         check("rst_id", core_block_id[i*W +: W], 0);
         check("rst_cnt", core_thread_count[i*TCW +: TCW], 0);
      end
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      reset = 1'b0;
      @(negedge clk);

      // tc=10, bs=4: blocks 4,4,2 to cores 0,1,2
      resp_delay = 5;
      base = n_disp;
      launch(10, 4, 4'hF);
      check("t1_busy", busy, 1);
      check("t1_core_reset", core_reset, 0);
      check("t1_no_start_yet", core_start, 0);
      @(negedge clk);
      check("t1_first_start", core_start, 4'b0001);
      wait_done(200, t);
      check("t1_done_latency", t - last_any_done, 3);
      check("t1_busy_off", busy, 0);
      check("t1_ndisp", n_disp - base, 3);
      for (int k = 0; k < 3; k++) check("t1_core_pick", disp_core[base+k], k);
      end_kernel();

      // tc=9, bs=1, only core 1 enabled
      resp_delay = 2;
      gap_chk = 1'b1;
      watch0 = 1'b1;
      bad0 = 0;
      base = n_disp;
      launch(9, 1, 4'b0010);
      check("t2_core_reset", core_reset, 4'b1101);
      wait_done(300, t);
      gap_chk = 1'b0;
      watch0 = 1'b0;
      check("t2_core0_held", bad0, 0);
      check("t2_ndisp", n_disp - base, 9);
      for (int k = 0; k < 9; k++) check("t2_core1_only", disp_core[base+k], 1);
      end_kernel();

      // clamped block sizes
      bs_list[0] = 0;
      bs_list[1] = 15;
      for (int s = 0; s < 2; s++) begin
         resp_delay = 3;
         base = n_disp;
         launch(20, bs_list[s], 4'hF);
         wait_done(200, t);
         check("t3_ndisp", n_disp - base, 3);
         end_kernel();
      end

      // tc=0: done without dispatch
      base = n_disp;
      launch(0, 4, 4'hF);
      check("t4_busy", busy, 1);
      check("t4_not_done", done, 0);
      @(negedge clk);
      check("t4_done", done, 1);
      check("t4_error", error, 0);
      check("t4_busy_off", busy, 0);
      check("t4_no_start", core_start, 0);
      check("t4_ndisp", n_disp - base, 0);
      end_kernel();

      // tc=5 with nothing enabled: rejected
      base = n_disp;
      launch(5, 4, 4'b0000);
      check("t4e_done", done, 1);
      check("t4e_error", error, 1);
      check("t4e_busy", busy, 0);
      @(negedge clk);
      check("t4e_error_held", error, 1);
      check("t4e_ndisp", n_disp - base, 0);
      end_kernel();

      // abort with two blocks in flight, then relaunch from id 0
      resp_delay = 50;
      base = n_disp;
      launch(20, 4, 4'hF);
      wait_disp(base, 2, 20);
      start = 1'b0;
      @(negedge clk);
      check("t5_start_off", core_start, 0);
      check("t5_reset_on", core_reset, 4'hF);
      check("t5_done", done, 0);
      check("t5_busy", busy, 0);
      exp_q.delete();
      @(negedge clk);
      check("t5_done_stays", done, 0);
      resp_delay = 5;
      base = n_disp;
      launch(3, 4, 4'hF);
      wait_done(200, t);
      check("t5_relaunch_ndisp", n_disp - base, 1);
      end_kernel();

      // simultaneous done on cores 0 and 3, spurious done on a free core
      resp_auto = 1'b0;
      base = n_disp;
      launch(24, 4, 4'hF);
      wait_disp(base, 4, 20);
      check("t6_all_running", core_start, 4'hF);
      @(negedge clk);
      extra_done = 4'b1001;
      @(negedge clk);
      extra_done = '0;
      check("t6_d1_start", core_start, 4'b0110);
      check("t6_d1_reset", core_reset, 4'b1001);
      @(negedge clk);
      check("t6_d2_reset", core_reset, 4'b0000);
      check("t6_d2_start", core_start, 4'b0110);
      extra_done = 4'b1000;
      @(negedge clk);
      extra_done = '0;
      check("t6_d3_start", core_start, 4'b0111);
      check("t6_d3_reset", core_reset, 4'b0000);
      @(negedge clk);
      check("t6_d4_start", core_start, 4'b1111);
      check("t6_ndisp", n_disp - base, 6);
      extra_done = 4'hF;
      @(negedge clk);
      extra_done = '0;
      wait_done(50, t);
      end_kernel();
      resp_auto = 1'b1;

      // reset in the middle of a run
      resp_delay = 50;
      launch(20, 4, 4'hF);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t7_reset_cores", core_reset, 4'hF);
      check("t7_start_off", core_start, 0);
      check("t7_busy", busy, 0);
      reset = 1'b0;
      start = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("t7_idle_busy", busy, 0);
      check("t7_idle_done", done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
